// File: rtl/seq_detector_pkg.sv
// Shared types and defaults for the parametrised serial pattern detector.
// Holds the FSM state encoding, reset defaults and the length clamp helper.
package seq_detector_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [7:0] PKG_DEF_PAT = 8'b0000_0101;
    localparam int         PKG_DEF_LEN = 3;

    // A zero or oversized length means "use the whole pattern register".
    function automatic int unsigned clamp_len(input int unsigned len_in,
                                              input int unsigned pat_w);
        if (len_in == 0 || len_in > pat_w)
            return pat_w;
        return len_in;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Shared building block of the test fabric; asynchronous reset Clr.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial bit-pattern detector with overlap control and match count.
// Optional macro SEQDET_STICKY_EN adds the sticky Seen output.
module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(PKG_DEF_PAT),
    parameter int               DEF_LEN = PKG_DEF_LEN,
    parameter int               CNT_W   = 8,
    localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             En,
    input  logic             X,
    input  logic             Load,
    input  logic [PAT_W-1:0] PatIn,
    input  logic [LEN_W-1:0] LenIn,
    input  logic             Overlap,
    input  logic             CntClr,
    output logic             Z,
    output logic [CNT_W-1:0] MatchCnt,
    output logic             Armed
`ifdef SEQDET_STICKY_EN
   ,output logic             Seen
`endif
);

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] RST_LEN  =
        LEN_W'(clamp_len(unsigned'(DEF_LEN), unsigned'(PAT_W)));

    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    state_t           r_state;
    logic             r_Z;

    logic [PAT_W-1:0] w_pat_nxt;
    logic [LEN_W-1:0] w_len_nxt;
    logic [PAT_W-1:0] w_hist_nxt;
    logic [LEN_W-1:0] w_fill_nxt;
    state_t           w_state_nxt;
    logic             w_Z_nxt;

    logic [PAT_W-1:0] w_mask;
    logic [PAT_W-1:0] w_hist_sh;
    logic [LEN_W-1:0] w_fill_inc;
    logic             w_accept;
    logic             w_hit;
    logic             w_match;

    // Only the low r_len bits of history and pattern take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++)
            w_mask[i] = (i < int'(r_len));
    end

    assign w_hist_sh  = {r_hist[PAT_W-2:0], X};
    assign w_fill_inc = (r_fill == FULL_LEN) ? r_fill : r_fill + LEN_W'(1);
    assign w_accept   = En && !Load;
    assign w_hit      = (((w_hist_sh ^ r_pat) & w_mask) == '0);
    assign w_match    = w_accept && (w_fill_inc >= r_len) && w_hit;

    always_comb begin
        w_pat_nxt   = r_pat;
        w_len_nxt   = r_len;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        w_state_nxt = r_state;
        w_Z_nxt     = 1'b0;
        if (Load) begin
            w_pat_nxt   = PatIn;
            w_len_nxt   = LEN_W'(clamp_len(32'(LenIn), unsigned'(PAT_W)));
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
            w_state_nxt = FILL;
        end else if (En) begin
            w_Z_nxt = w_match;
            if (w_match && !Overlap) begin
                // Non-overlapping: the matched bits may not seed the next match.
                w_hist_nxt  = '0;
                w_fill_nxt  = '0;
                w_state_nxt = FILL;
            end else begin
                w_hist_nxt = w_hist_sh;
                w_fill_nxt = w_fill_inc;
                case (r_state)
                    FILL:    w_state_nxt = (w_fill_inc >= r_len) ? ARMED : FILL;
                    ARMED:   w_state_nxt = ARMED;
                    default: w_state_nxt = FILL;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_pat   <= DEF_PAT;
            r_len   <= RST_LEN;
            r_hist  <= '0;
            r_fill  <= '0;
            r_state <= FILL;
            r_Z     <= 1'b0;
        end else begin
            r_pat   <= w_pat_nxt;
            r_len   <= w_len_nxt;
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
            r_state <= w_state_nxt;
            r_Z     <= w_Z_nxt;
        end
    end

    assign Z     = r_Z;
    assign Armed = (r_state == ARMED);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .Clk   (Clk),
        .Clr   (Clr),
        .i_inc (w_match),
        .i_clr (CntClr),
        .o_cnt (MatchCnt)
    );

`ifdef SEQDET_STICKY_EN
    logic r_seen;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr)
            r_seen <= 1'b0;
        else if (Load)
            r_seen <= 1'b0;
        else if (w_match)
            r_seen <= 1'b1;
    end

    assign Seen = r_seen;
`endif

endmodule
